// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined slice adder.
// Holds the per-stage control struct and the N/CHUNK geometry checks.
package adder_pkg;

   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

   function automatic int adder_stages(input int n, input int chunk);
      return n / chunk;
   endfunction

   function automatic bit adder_cfg_ok(input int n, input int chunk);
      return (chunk > 0) && (n >= chunk) && ((n % chunk) == 0);
   endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One registered CHUNK-bit slice add with carry in/out and a valid bit.
// Latency 1 cycle; loads only when advance=1, otherwise holds (stalls with the pipe).
module adder_chunk_stage
   import adder_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             advance,
   input  stage_ctl_t       ctl_in,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output stage_ctl_t       ctl_out,
   output logic [CHUNK-1:0] sum
);

   logic [CHUNK:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ctl_in.carry};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_out <= '0;
         sum     <= '0;
      end else if (advance) begin
         ctl_out <= '{valid: ctl_in.valid, carry: total[CHUNK]};
         sum     <= total[CHUNK-1:0];
      end
   end

endmodule

// File: rtl/pipelined_nbit_adder.sv
// Pipelined N-bit add/subtract, one CHUNK-bit slice per stage; ADDER_OVF_FLAG_EN adds the ovf port.
// Latency STAGES cycles from accept to out_valid, one beat per cycle.
// Backpressure: the whole pipe stalls while out_valid && !out_ready; in_ready is the advance enable.
module pipelined_nbit_adder
   import adder_pkg::*;
#(
   parameter int N     = 32,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
`ifdef ADDER_OVF_FLAG_EN
   output logic         c_out,
   output logic         ovf
`else
   output logic         c_out
`endif
);

   localparam int STAGES = adder_stages(N, CHUNK);

   if (!adder_cfg_ok(N, CHUNK)) begin : g_cfg_err
      $error("pipelined_nbit_adder: N (%0d) must be a positive multiple of CHUNK (%0d)", N, CHUNK);
   end

   logic         advance;
   logic [N-1:0] b_eff;
   logic         cin_eff;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign b_eff    = sub ? ~b : b;
   assign cin_eff  = sub ? ~c_in : c_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CHUNK;

      // Operand bits from this slice upward, time-aligned to this stage.
      logic [N-1:LO]       a_up;
      logic [N-1:LO]       b_up;
      logic [LO+CHUNK-1:0] res;
      stage_ctl_t          ctl_in;
      stage_ctl_t          ctl_out;
      logic [CHUNK-1:0]    sum_slice;

      if (k == 0) begin : g_first
         assign a_up   = a;
         assign b_up   = b_eff;
         assign ctl_in = '{valid: in_valid, carry: cin_eff};
         assign res    = sum_slice;
      end else begin : g_next
         logic [LO-1:0] lo_dly;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_up   <= '0;
               b_up   <= '0;
               lo_dly <= '0;
            end else if (advance) begin
               a_up   <= g_stage[k-1].a_up[N-1:LO];
               b_up   <= g_stage[k-1].b_up[N-1:LO];
               lo_dly <= g_stage[k-1].res;
            end
         end

         assign ctl_in = g_stage[k-1].ctl_out;
         assign res    = {sum_slice, lo_dly};
      end

      adder_chunk_stage #(
         .CHUNK (CHUNK)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .advance (advance),
         .ctl_in  (ctl_in),
         .a       (a_up[LO +: CHUNK]),
         .b       (b_up[LO +: CHUNK]),
         .ctl_out (ctl_out),
         .sum     (sum_slice)
      );
   end

   assign out_valid = g_stage[STAGES-1].ctl_out.valid;
   assign c_out     = g_stage[STAGES-1].ctl_out.carry;
   assign sum       = g_stage[STAGES-1].res;

`ifdef ADDER_OVF_FLAG_EN
   logic a_sign;
   logic b_sign;

   // Operand signs ride alongside the top slice so ovf lines up with sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sign <= 1'b0;
         b_sign <= 1'b0;
      end else if (advance) begin
         a_sign <= g_stage[STAGES-1].a_up[N-1];
         b_sign <= g_stage[STAGES-1].b_up[N-1];
      end
   end

   assign ovf = (a_sign == b_sign) && (sum[N-1] != a_sign);
`endif

endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// Bench for pipelined_nbit_adder: an N=8/CHUNK=4 instance and an N=32/CHUNK=8 instance
// checked against an arithmetic reference model; define ADDER_OVF_FLAG_EN to cover ovf.
module tb_pipelined_nbit_adder;

   localparam int N8  = 8;
   localparam int C8  = 4;
   localparam int S8  = N8 / C8;
   localparam int N32 = 32;
   localparam int C32 = 8;
   localparam int S32 = N32 / C32;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic        in_valid8, in_ready8, c_in8, sub8, out_valid8, out_ready8, c_out8;
   logic [7:0]  a8, b8, sum8;
   logic        in_valid32, in_ready32, c_in32, sub32, out_valid32, out_ready32, c_out32;
   logic [31:0] a32, b32, sum32;
`ifdef ADDER_OVF_FLAG_EN
   logic        ovf8, ovf32;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipelined_nbit_adder #(.N(N8), .CHUNK(C8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .c_in      (c_in8),
      .sub       (sub8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
`ifdef ADDER_OVF_FLAG_EN
      .c_out     (c_out8),
      .ovf       (ovf8)
`else
      .c_out     (c_out8)
`endif
   );

   pipelined_nbit_adder #(.N(N32), .CHUNK(C32)) u_dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .a         (a32),
      .b         (b32),
      .c_in      (c_in32),
      .sub       (sub32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .sum       (sum32),
`ifdef ADDER_OVF_FLAG_EN
      .c_out     (c_out32),
      .ovf       (ovf32)
`else
      .c_out     (c_out32)
`endif
   );

   // Plain arithmetic: unsigned result mod 2^n, carry / no-borrow, signed range overflow.
   function automatic res_t ref_add(input int n, input logic [31:0] ra, input logic [31:0] rb,
                                    input logic rcin, input logic rsub);
      res_t   r;
      longint span, half, ua, ub, uc, full, sa, sb, sr;
      span = longint'(1) << n;
      half = span / 2;
      ua   = longint'(ra) % span;
      ub   = longint'(rb) % span;
      uc   = rcin ? 1 : 0;
      if (!rsub) begin
         full   = ua + ub + uc;
         r.cout = (full >= span);
      end else begin
         full   = ua - ub - uc;
         r.cout = (ua >= ub + uc);
         if (full < 0) full = full + span;
      end
      r.sum = 32'(full % span);
      sa    = (ua >= half) ? ua - span : ua;
      sb    = (ub >= half) ? ub - span : ub;
      sr    = rsub ? (sa - sb - uc) : (sa + sb + uc);
      r.ovf = (sr >= half) || (sr < -half);
      return r;
   endfunction

   task automatic idle_inputs();
      in_valid8   = 1'b0; a8  = '0; b8  = '0; c_in8  = 1'b0; sub8  = 1'b0; out_ready8  = 1'b1;
      in_valid32  = 1'b0; a32 = '0; b32 = '0; c_in32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk); #1;
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b expected 0", out_valid8); end
      checks++; if ({sum8, c_out8} !== 9'h0) begin errors++; $display("FAIL reset_sum8: got %h/%b expected 00/0", sum8, c_out8); end
      checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid32: got %b expected 0", out_valid32); end
      checks++; if ({sum32, c_out32} !== 33'h0) begin errors++; $display("FAIL reset_sum32: got %h/%b expected 0/0", sum32, c_out32); end
`ifdef ADDER_OVF_FLAG_EN
      checks++; if ({ovf8, ovf32} !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b%b expected 00", ovf8, ovf32); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if ({in_ready8, in_ready32} !== 2'b11) begin errors++; $display("FAIL reset_in_ready: got %b%b expected 11", in_ready8, in_ready32); end
      checks++; if ({out_valid8, out_valid32} !== 2'b00) begin errors++; $display("FAIL reset_release_valid: got %b%b expected 00", out_valid8, out_valid32); end
   endtask

   task automatic test_single8(input string name, input logic [7:0] ta, input logic [7:0] tb,
                               input logic tcin, input logic tsub, input logic [7:0] esum,
                               input logic ecout, input logic eovf);
      int lat;
      @(negedge clk);
      a8 = ta; b8 = tb; c_in8 = tcin; sub8 = tsub; in_valid8 = 1'b1; out_ready8 = 1'b1;
      #1;
      checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready8); end
      @(negedge clk);
      // Scramble the live operands so later stages must use their own skewed copies.
      in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c_in8 = 1'($urandom); sub8 = 1'($urandom);
      lat = 1;
      #1;
      while (out_valid8 !== 1'b1 && lat < 10) begin
         @(negedge clk); #1;
         lat++;
      end
      checks++; if (lat !== S8) begin errors++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, S8); end
      checks++; if ({sum8, c_out8} !== {esum, ecout}) begin
         errors++; $display("FAIL %s_result: got sum=%h c_out=%b expected sum=%h c_out=%b (ovf %b)", name, sum8, c_out8, esum, ecout, eovf);
      end
`ifdef ADDER_OVF_FLAG_EN
      checks++; if (ovf8 !== eovf) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, ovf8, eovf); end
`endif
      @(negedge clk); #1;
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL %s_no_dup: got out_valid=%b expected 0", name, out_valid8); end
   endtask

   task automatic test_random8();
      res_t e;
      logic [7:0] ta, tb;
      logic tc, ts;
      for (int i = 0; i < 6; i++) begin
         ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom); ts = 1'($urandom);
         e  = ref_add(N8, {24'h0, ta}, {24'h0, tb}, tc, ts);
         test_single8("rand8", ta, tb, tc, ts, e.sum[7:0], e.cout, e.ovf);
      end
   endtask

   task automatic test_back_to_back32();
      res_t q[$];
      res_t e;
      logic [31:0] ra [100];
      logic [31:0] rb [100];
      logic rc [100];
      logic rs [100];
      int sent = 0;
      int got  = 0;
      for (int i = 0; i < 100; i++) begin
         ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'($urandom); rs[i] = 1'($urandom);
      end
      out_ready32 = 1'b1;
      for (int cyc = 0; cyc < 250 && got < 100; cyc++) begin
         @(negedge clk);
         if (sent < 100) begin
            a32 = ra[sent]; b32 = rb[sent]; c_in32 = rc[sent]; sub32 = rs[sent]; in_valid32 = 1'b1;
         end else begin
            in_valid32 = 1'b0;
         end
         #1;
         if (out_valid32 && out_ready32) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_spurious: got output %h with nothing expected", sum32);
            end else begin
               e = q.pop_front();
               if ({sum32, c_out32} !== {e.sum, e.cout}) begin
                  errors++; $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", got, sum32, c_out32, e.sum, e.cout);
               end
            end
            checks++; if (cyc !== got + S32) begin errors++; $display("FAIL b2b_timing[%0d]: got cycle %0d expected %0d", got, cyc, got + S32); end
            got++;
         end
         if (in_valid32 && in_ready32) begin
            q.push_back(ref_add(N32, a32, b32, c_in32, sub32));
            sent++;
         end
      end
      in_valid32 = 1'b0;
      checks++; if (got !== 100) begin errors++; $display("FAIL b2b_count: got %0d results expected 100", got); end
   endtask

   task automatic test_backpressure32();
      res_t q[$];
      res_t e;
      int sent   = 0;
      int got    = 0;
      int stalls = 0;
      for (int cyc = 0; cyc < 600 && got < 60; cyc++) begin
         @(negedge clk);
         if (cyc >= 10 && cyc < 15)  out_ready32 = 1'b0;
         else if (cyc < 30)          out_ready32 = 1'b1;
         else                        out_ready32 = ($urandom_range(0, 9) < 7);
         if (sent < 60 && (cyc < 30 || $urandom_range(0, 9) < 8)) begin
            if (!in_valid32 || in_ready32) begin
               a32 = $urandom; b32 = $urandom; c_in32 = 1'($urandom); sub32 = 1'($urandom);
            end
            in_valid32 = 1'b1;
         end else begin
            in_valid32 = 1'b0;
         end
         #1;
         if (out_valid32 && !out_ready32) begin
            stalls++;
            checks++; if (in_ready32 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0 at cycle %0d", in_ready32, cyc); end
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL bp_hold_spurious: got %h with nothing expected", sum32);
            end else if ({sum32, c_out32} !== {q[0].sum, q[0].cout}) begin
               errors++; $display("FAIL bp_hold: got %h/%b expected %h/%b", sum32, c_out32, q[0].sum, q[0].cout);
            end
         end
         if (out_valid32 && out_ready32) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL bp_spurious: got output %h with nothing expected", sum32);
            end else begin
               e = q.pop_front();
               if ({sum32, c_out32} !== {e.sum, e.cout}) begin
                  errors++; $display("FAIL bp_result[%0d]: got %h/%b expected %h/%b", got, sum32, c_out32, e.sum, e.cout);
               end
            end
            got++;
         end
         if (in_valid32 && in_ready32) begin
            q.push_back(ref_add(N32, a32, b32, c_in32, sub32));
            sent++;
         end
      end
      in_valid32  = 1'b0;
      out_ready32 = 1'b1;
      checks++; if (got !== 60 || q.size() !== 0) begin errors++; $display("FAIL bp_count: got %0d results, %0d pending expected 60, 0", got, q.size()); end
      checks++; if (stalls < 5) begin errors++; $display("FAIL bp_stall_seen: got %0d stalled cycles expected at least 5", stalls); end
   endtask

   task automatic test_reset_midstream32();
      res_t e;
      int lat;
      out_ready32 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a32 = $urandom; b32 = $urandom; c_in32 = 1'($urandom); sub32 = 1'($urandom); in_valid32 = 1'b1;
      end
      @(negedge clk);
      in_valid32 = 1'b0;
      #1;
      checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL mid_prefill: got out_valid=%b expected 1", out_valid32); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got out_valid=%b expected 0", out_valid32); end
      checks++; if ({sum32, c_out32} !== 33'h0) begin errors++; $display("FAIL mid_sum_clear: got %h/%b expected 0/0", sum32, c_out32); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got out_valid=%b expected 0", i, out_valid32); end
      end
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; c_in32 = 1'($urandom); sub32 = 1'($urandom); in_valid32 = 1'b1;
      #1;
      e = ref_add(N32, a32, b32, c_in32, sub32);
      checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready32); end
      @(negedge clk);
      in_valid32 = 1'b0;
      lat = 1;
      #1;
      while (out_valid32 !== 1'b1 && lat < 12) begin
         @(negedge clk); #1;
         lat++;
      end
      checks++; if (lat !== S32) begin errors++; $display("FAIL mid_latency: got %0d cycles expected %0d", lat, S32); end
      checks++; if ({sum32, c_out32} !== {e.sum, e.cout}) begin errors++; $display("FAIL mid_result: got %h/%b expected %h/%b", sum32, c_out32, e.sum, e.cout); end
`ifdef ADDER_OVF_FLAG_EN
      checks++; if (ovf32 !== e.ovf) begin errors++; $display("FAIL mid_ovf: got %b expected %b", ovf32, e.ovf); end
`endif
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_single8("carry_boundary", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      test_single8("sub_no_borrow",  8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
      test_single8("sub_borrow",     8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      test_single8("add_ovf",        8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      test_single8("sub_ovf",        8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      test_single8("add_cin",        8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
      test_random8();
      test_back_to_back32();
      test_backpressure32();
      test_reset_midstream32();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_nbit_adder.md
Name: pipelined_nbit_adder

Overview:
- Parametrised, pipelined successor to the combinational N-bit adder.
- Splits an N-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides with full backpressure.
- Sits in datapaths that need wide adds at high clock rates, e.g. accumulators and address generators.

Parameters:
N, 32, operand/result width; N must be an integer multiple of CHUNK (elaboration error otherwise)
CHUNK, 8, slice width added per stage; STAGES = N/CHUNK is a derived localparam, STAGES >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  N  operand A
b  input  N  operand B
c_in  input  1  carry-in (borrow-in when sub=1)
sub  input  1  0: a+b+c_in; 1: a+~b+~c_in (= a-b-c_in mod 2^N)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  N  result
c_out  output  1  carry out of bit N-1 (for sub: 1 = no borrow)
ovf  output  1  signed overflow (only with ADDER_OVF_FLAG_EN)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: all stage valid bits, out_valid, sum, c_out, ovf and the inter-stage carries clear to 0 immediately. in_ready reads 1 after reset.
- Pipeline advance: advance = !out_valid || out_ready. in_ready = advance. Every stage register loads only when advance=1; otherwise all stages hold. There are no bubbles collapsed, so the whole pipe stalls as one.
- Accept: a beat is taken when in_valid && in_ready.
  - Stage 0 registers slice 0 of (a + b' + cin'), with b' = sub ? ~b : b and cin' = sub ? ~c_in : c_in.
  - Stage 0 also registers the carry, the valid bit, and the upper slices of a and b' (input skew registers).
- Stage k (1..STAGES-1): adds slice k of the delayed a and b' plus the registered carry from stage k-1. Lower result slices are carried forward through deskew registers.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1. That is, the result is registered at the last stage, and out_valid rises STAGES cycles after the accept cycle with no stalls.
- Throughput: 1 beat/cycle while out_ready=1. Results emerge in input order.
- Output hold: while out_valid && !out_ready, sum, c_out and ovf are stable and no stage changes.
- Empty stages: when in_valid=0 and advance=1, a bubble (valid=0) enters stage 0. Data registers of invalid stages are don't-care.
- Simultaneous events: when the output drains and the input is accepted in the same cycle, both occur.
- STAGES=1: behaves as a single registered adder with latency 1.
- Wrap-around: results are mod 2^N. For example, 0xFF+0x01 with N=8 gives sum 0x00 and c_out=1.
- Mid-operation reset: in-flight beats are discarded. There is no output pulse after reset release.

Optional Feature:
- Macro: ADDER_OVF_FLAG_EN.
- Defined: ovf port exists. ovf = (a[N-1] == b'[N-1]) && (sum[N-1] != a[N-1]), computed in the last stage from the delayed sign bits. It is valid alongside sum and clears on reset.
- Undefined: the ovf port and its sign-bit delay registers are absent.

Decomposition:
- Package adder_pkg holds:
  - the STAGES computation function;
  - the localparam checks (N % CHUNK == 0);
  - a typedef for the stage control struct {valid, carry}.
- Sub-module adder_chunk_stage (parameter CHUNK) is natural: it performs the registered slice add with carry in/out, valid, and advance enable. It is instantiated STAGES times in a generate loop. Skew/deskew registers live in the top module.

Test Plan:
- N=8, CHUNK=4: a=0xFF, b=0x01, c_in=0, sub=0, out_ready=1 -> 2 cycles later sum=0x00, c_out=1 (checks carry across the stage boundary).
- N=8, CHUNK=4: a=0x10, b=0x01, c_in=0, sub=1 -> sum=0x0F, c_out=1. Then a=0x00, b=0x01 -> sum=0xFF, c_out=0.
- N=32, CHUNK=8: stream 100 random beats back-to-back with out_ready=1 -> results match the reference model in order, one per cycle after a 4-cycle fill.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, sum held constant, no beats lost or duplicated after release.
- Reset: assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0 immediately. After release, no stale result appears and the first new beat returns after STAGES cycles.
- ADDER_OVF_FLAG_EN, N=8, CHUNK=4: a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
